// File: rtl/io_deq_policy_if.sv
// Dequeue-side handshake bundle between the IO issue queue and its deq policy.
// Optional IO_DEQ_PERF_EN adds the perf counter outputs.
`ifndef ISSUE_QUEUE_DEPTH
`define ISSUE_QUEUE_DEPTH 8
`endif

interface io_deq_policy_if #(
  parameter int DEPTH   = `ISSUE_QUEUE_DEPTH,
  parameter int IDX_W   = $clog2(DEPTH),
  parameter int STALL_W = 8
);
  logic               flush;
  logic [DEPTH-1:0]   valid_dec;
  logic [DEPTH-1:0]   ready_dec;
  logic [DEPTH-1:0]   enq_ptr_oh;
  logic               issue_ready;
  logic               issue_valid;
  logic [IDX_W-1:0]   issue_idx;
  logic [DEPTH-1:0]   deq_fire_oh;
  logic [DEPTH-1:0]   deq_ptr_oh;
  logic [STALL_W-1:0] head_stall_cnt;
`ifdef IO_DEQ_PERF_EN
  logic [31:0]        perf_issue_cnt;
  logic [31:0]        perf_stall_cnt;
`endif

  modport master (
    output flush, valid_dec, ready_dec,
    output enq_ptr_oh, issue_ready,
    input  issue_valid, issue_idx,
    input  deq_fire_oh, deq_ptr_oh,
`ifdef IO_DEQ_PERF_EN
    input  perf_issue_cnt, perf_stall_cnt,
`endif
    input  head_stall_cnt
  );

  modport slave (
    input  flush, valid_dec, ready_dec,
    input  enq_ptr_oh, issue_ready,
    output issue_valid, issue_idx,
    output deq_fire_oh, deq_ptr_oh,
`ifdef IO_DEQ_PERF_EN
    output perf_issue_cnt, perf_stall_cnt,
`endif
    output head_stall_cnt
  );
endinterface

// File: rtl/io_deq_policy.sv
// In-order issue queue dequeue pointer policy: issue, advance, flush realign.
// Optional IO_DEQ_PERF_EN adds perf_issue_cnt / perf_stall_cnt.
`ifndef ISSUE_QUEUE_DEPTH
`define ISSUE_QUEUE_DEPTH 8
`endif

module io_deq_policy #(
  parameter int DEPTH   = `ISSUE_QUEUE_DEPTH,
  parameter int IDX_W   = $clog2(DEPTH),
  parameter int STALL_W = 8
) (
  input  logic           clock,
  input  logic           reset,
  io_deq_policy_if.slave io
);

  typedef enum logic {RUN, FLUSH} state_e;

  state_e             state_q, state_d;
  logic [DEPTH-1:0]   ptr_q, ptr_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic             head_vld;
  logic             head_hit;
  logic             iss_vld;
  logic             fire;
  logic [DEPTH-1:0] fire_oh;
  logic [DEPTH-1:0] rem;
  logic [IDX_W-1:0] ptr_idx;
  logic [IDX_W-1:0] base_idx;

  function automatic logic [IDX_W-1:0] enc(
    input logic [DEPTH-1:0] oh
  );
    enc = '0;
    for (int i = 0; i < DEPTH; i++)
      if (oh[i]) enc = enc | IDX_W'(i);
  endfunction

  function automatic logic [IDX_W-1:0] hi_idx(
    input logic [DEPTH-1:0] vec
  );
    hi_idx = '0;
    for (int i = 0; i < DEPTH; i++)
      if (vec[i]) hi_idx = IDX_W'(i);
  endfunction

  // First set bit of vec, searching upward from start with wrap.
  function automatic logic [DEPTH-1:0] scan(
    input logic [DEPTH-1:0] vec,
    input logic [IDX_W-1:0] start
  );
    logic found;
    int   j;
    scan  = '0;
    found = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      j = (int'(start) + k) % DEPTH;
      if (!found && vec[j]) begin
        scan[j] = 1'b1;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    ptr_idx  = enc(ptr_q);
    base_idx = IDX_W'((int'(hi_idx(io.valid_dec)) + 1) % DEPTH);
    head_vld = |(ptr_q & io.valid_dec);
    head_hit = |(ptr_q & io.valid_dec & io.ready_dec);
    iss_vld  = head_hit & (state_q == RUN)
             & ~io.flush & ~reset;
    fire     = iss_vld & io.issue_ready;
    fire_oh  = fire ? ptr_q : '0;
    rem      = io.valid_dec & ~fire_oh;
    state_d  = io.flush ? FLUSH : RUN;

    ptr_d = ptr_q;
    if (state_q == FLUSH) begin
      if (io.valid_dec == '0)
        ptr_d = io.enq_ptr_oh;
      else
        ptr_d = scan(io.valid_dec, base_idx);
    end else if (io.flush) begin
      ptr_d = ptr_q;
    end else if (rem == '0) begin
      ptr_d = io.enq_ptr_oh;
    end else if (fire) begin
      ptr_d = scan(rem, ptr_idx);
    end

    stall_d = stall_q;
    if (fire || io.flush || !head_vld)
      stall_d = '0;
    else if (stall_q != '1)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      ptr_q   <= DEPTH'(1);
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      stall_q <= stall_d;
    end
  end

  assign io.issue_valid    = iss_vld;
  assign io.issue_idx      = ptr_idx;
  assign io.deq_fire_oh    = fire_oh;
  assign io.deq_ptr_oh     = ptr_q;
  assign io.head_stall_cnt = stall_q;

`ifdef IO_DEQ_PERF_EN
  logic [31:0] perf_iss_q, perf_iss_d;
  logic [31:0] perf_stl_q, perf_stl_d;

  always_comb begin
    perf_iss_d = perf_iss_q + 32'(fire);
    perf_stl_d = perf_stl_q
               + 32'((state_q == RUN) & head_vld & ~fire);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_iss_q <= '0;
      perf_stl_q <= '0;
    end else begin
      perf_iss_q <= perf_iss_d;
      perf_stl_q <= perf_stl_d;
    end
  end

  assign io.perf_issue_cnt = perf_iss_q;
  assign io.perf_stall_cnt = perf_stl_q;
`endif

  a_onehot: assert property (
    @(posedge clock) disable iff (reset) $onehot(ptr_q)
  );

endmodule
